// File: rtl/vmicro16_apb_intercon_rr_if.sv
// APB3 interconnect bundle: per-master request/response lanes on the S_* side,
// one shared request bus with per-slave select/return lanes on the M_* side.
interface vmicro16_apb_intercon_rr_if #(
  parameter int MASTER_PORTS = 2,
  parameter int SLAVE_PORTS  = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16
);
  logic [MASTER_PORTS*ADDR_WIDTH-1:0] S_PADDR;
  logic [MASTER_PORTS-1:0]            S_PWRITE;
  logic [MASTER_PORTS-1:0]            S_PSELx;
  logic [MASTER_PORTS-1:0]            S_PENABLE;
  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA;
  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA;
  logic [MASTER_PORTS-1:0]            S_PREADY;
  logic [MASTER_PORTS-1:0]            S_PSLVERR;

  logic [ADDR_WIDTH-1:0]              M_PADDR;
  logic                               M_PWRITE;
  logic [SLAVE_PORTS-1:0]             M_PSELx;
  logic                               M_PENABLE;
  logic [DATA_WIDTH-1:0]              M_PWDATA;
  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA;
  logic [SLAVE_PORTS-1:0]             M_PREADY;

  // Interconnect's view: accepts master requests, drives the shared slave bus.
  modport slave (
    input  S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    output S_PRDATA, S_PREADY, S_PSLVERR,
    output M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
    input  M_PRDATA, M_PREADY
  );

  // Surrounding system's view: cores drive requests, peripherals answer.
  modport master (
    output S_PADDR, S_PWRITE, S_PSELx, S_PENABLE, S_PWDATA,
    input  S_PRDATA, S_PREADY, S_PSLVERR,
    input  M_PADDR, M_PWRITE, M_PSELx, M_PENABLE, M_PWDATA,
    output M_PRDATA, M_PREADY
  );
endinterface

// File: rtl/vmicro16_apb_intercon_rr.sv
// Round-robin APB3 shared-bus interconnect: arbitrates MASTER_PORTS masters onto
// one slave bus, decodes the slave from the upper address bits, returns
// PRDATA/PREADY/PSLVERR to the granted master, and errors unmapped or stalled accesses.
module vmicro16_apb_intercon_rr #(
  parameter int MASTER_PORTS = 2,
  parameter int SLAVE_PORTS  = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int SLAVE_SHIFT  = 8,
  parameter int TIMEOUT      = 255
) (
  input logic clk,
  input logic reset,
  vmicro16_apb_intercon_rr_if.slave bus
);

  localparam int MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                  state, state_next;
  logic [MASTER_PORTS-1:0] req;
  logic [MW-1:0]           last_grant, grant, arb_idx, cand, resp_master;
  logic                    arb_found;
  logic [ADDR_WIDTH-1:0]   arb_addr, arb_slave;
  logic                    arb_mapped;
  logic [SW-1:0]           sel_idx;
  logic [CW-1:0]           cnt;
  logic                    slave_ready, timed_out;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    resp_err;

  assign req         = bus.S_PSELx & bus.S_PENABLE;
  assign arb_addr    = bus.S_PADDR[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign arb_slave   = arb_addr >> SLAVE_SHIFT;
  assign arb_mapped  = arb_slave < ADDR_WIDTH'(SLAVE_PORTS);
  assign slave_ready = bus.M_PREADY[sel_idx];
  assign timed_out   = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

  // Round-robin pick: first requester after last_grant, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= MASTER_PORTS; k++) begin
      cand = MW'((32'(last_grant) + k) % MASTER_PORTS);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Transfer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus the response that gets registered on entry to RESP.
  always_comb begin
    state_next  = state;
    resp_master = grant;
    resp_data   = '0;
    resp_err    = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) begin
          resp_master = arb_idx;
          if (arb_mapped) begin
            state_next = SETUP;
          end else begin
            state_next = RESP;
            resp_err   = 1'b1;
          end
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        if (slave_ready) begin
          state_next = RESP;
          resp_data  = bus.M_PRDATA[sel_idx*DATA_WIDTH +: DATA_WIDTH];
        end else if (timed_out) begin
          state_next = RESP;
          resp_err   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slave-side select/enable follow the state so reset drops them immediately.
  always_comb begin
    bus.M_PSELx   = '0;
    bus.M_PENABLE = (state == ACCESS);
    if (state == SETUP || state == ACCESS) bus.M_PSELx[sel_idx] = 1'b1;
  end

  // Grant bookkeeping, latched request, wait counter and registered master responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant    <= MW'(MASTER_PORTS - 1);
      grant         <= '0;
      sel_idx       <= '0;
      cnt           <= '0;
      bus.M_PADDR   <= '0;
      bus.M_PWRITE  <= 1'b0;
      bus.M_PWDATA  <= '0;
      bus.S_PREADY  <= '0;
      bus.S_PSLVERR <= '0;
      bus.S_PRDATA  <= '0;
    end else begin
      if (state == IDLE && arb_found) begin
        last_grant   <= arb_idx;
        grant        <= arb_idx;
        sel_idx      <= SW'(arb_slave);
        bus.M_PADDR  <= arb_addr;
        bus.M_PWRITE <= bus.S_PWRITE[arb_idx];
        bus.M_PWDATA <= bus.S_PWDATA[arb_idx*DATA_WIDTH +: DATA_WIDTH];
      end
      if (state == ACCESS) cnt <= cnt + 1'b1;
      else                 cnt <= '0;
      bus.S_PREADY  <= '0;
      bus.S_PSLVERR <= '0;
      bus.S_PRDATA  <= '0;
      if (state_next == RESP) begin
        bus.S_PREADY[resp_master]                         <= 1'b1;
        bus.S_PSLVERR[resp_master]                        <= resp_err;
        bus.S_PRDATA[resp_master*DATA_WIDTH +: DATA_WIDTH] <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_vmicro16_apb_intercon_rr.sv
// Bench for the round-robin APB interconnect: scripted master/slave agents are
// driven from a transaction-level model that predicts every bus cycle.
module tb_vmicro16_apb_intercon_rr;
  localparam int MP = 2, SP = 4, AW = 16, DW = 16, SS = 8, TO = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vmicro16_apb_intercon_rr_if #(.MASTER_PORTS(MP), .SLAVE_PORTS(SP),
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  vmicro16_apb_intercon_rr #(.MASTER_PORTS(MP), .SLAVE_PORTS(SP), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .SLAVE_SHIFT(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;   // what the addressed slave returns
    int unsigned   wt;      // slave wait cycles before PREADY
    int unsigned   gap;     // idle cycles before the master starts
  } req_t;

  int checks = 0, errors = 0;
  int cyc = 0, last_r = -1, last_g = MP - 1;

  // Transaction currently owning the bus in the model.
  bit            t_active = 1'b0, t_mapped, t_err;
  int            t_m, t_slave, t_g, t_r;
  int unsigned   t_wt;
  logic [DW-1:0] t_rdata, t_sdata;
  logic [AW-1:0] lat_addr = '0;
  logic          lat_wr   = 1'b0;
  logic [DW-1:0] lat_wd   = '0;

  req_t        mq [MP][$];
  req_t        cur [MP];
  int          mphase [MP];
  bit          mloaded [MP];
  int unsigned mgap [MP];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_outputs(input logic [SP-1:0] e_sel, input logic e_en,
                               input logic [MP-1:0] e_rdy, input logic [MP-1:0] e_err,
                               input logic [MP*DW-1:0] e_rd);
    check("m_psel",    64'(bus.M_PSELx),   64'(e_sel));
    check("m_penable", 64'(bus.M_PENABLE), 64'(e_en));
    check("s_pready",  64'(bus.S_PREADY),  64'(e_rdy));
    check("s_pslverr", 64'(bus.S_PSLVERR), 64'(e_err));
    check("s_prdata",  64'(bus.S_PRDATA),  64'(e_rd));
    check("m_paddr",   64'(bus.M_PADDR),   64'(lat_addr));
    check("m_pwrite",  64'(bus.M_PWRITE),  64'(lat_wr));
    check("m_pwdata",  64'(bus.M_PWDATA),  64'(lat_wd));
  endtask

  task automatic push(input int m, input logic [AW-1:0] a, input logic w,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                      input int unsigned wt, input int unsigned gap);
    req_t r;
    r.addr = a; r.wr = w; r.wdata = wd; r.rdata = rd; r.wt = wt; r.gap = gap;
    mq[m].push_back(r);
  endtask

  function automatic bit idle();
    bit b = (cyc >= last_r);
    for (int i = 0; i < MP; i++)
      if (mq[i].size() != 0 || mloaded[i] || mphase[i] != 0) b = 1'b0;
    return b;
  endfunction

  task automatic drive_masters();
    logic [MP*AW-1:0] pa;
    logic [MP*DW-1:0] pw;
    logic [MP-1:0]    ps, pe, wr;
    for (int i = 0; i < MP; i++) begin
      ps[i] = (mphase[i] != 0);
      pe[i] = (mphase[i] == 2);
      pa[i*AW +: AW] = ps[i] ? cur[i].addr  : AW'($urandom);
      pw[i*DW +: DW] = ps[i] ? cur[i].wdata : DW'($urandom);
      wr[i]          = ps[i] ? cur[i].wr    : 1'($urandom);
    end
    bus.S_PADDR = pa; bus.S_PWDATA = pw; bus.S_PSELx = ps;
    bus.S_PENABLE = pe; bus.S_PWRITE = wr;
  endtask

  // One clock cycle: check DUT against the model, then advance agents and model.
  task automatic step();
    logic [SP-1:0]    e_sel, rdy;
    logic             e_en;
    logic [MP-1:0]    e_rdy, e_err;
    logic [MP*DW-1:0] e_rd;
    logic [SP*DW-1:0] rd;
    bit               found;
    int               gm, cand, len;
    req_t             a;
    @(negedge clk);
    cyc++;
    e_sel = '0; e_en = 1'b0; e_rdy = '0; e_err = '0; e_rd = '0;
    if (t_active) begin
      if (t_mapped && cyc >= t_g + 1 && cyc < t_r) e_sel[t_slave] = 1'b1;
      if (t_mapped && cyc >= t_g + 2 && cyc < t_r) e_en = 1'b1;
      if (cyc == t_r) begin
        e_rdy[t_m] = 1'b1;
        e_err[t_m] = t_err;
        e_rd[t_m*DW +: DW] = t_rdata;
      end
    end
    check_outputs(e_sel, e_en, e_rdy, e_err, e_rd);
    if (t_active && cyc == t_r) begin
      t_active = 1'b0;
      mphase[t_m] = 0;
      mloaded[t_m] = 1'b0;
    end
    for (int i = 0; i < MP; i++) begin
      case (mphase[i])
        0: begin
          if (!mloaded[i] && mq[i].size() > 0) begin
            cur[i] = mq[i].pop_front();
            mloaded[i] = 1'b1;
            mgap[i] = cur[i].gap;
          end
          if (mloaded[i]) begin
            if (mgap[i] == 0) mphase[i] = 1;
            else mgap[i]--;
          end
        end
        1: mphase[i] = 2;
        default: ;
      endcase
    end
    drive_masters();
    // Slaves: unselected ones babble; the selected one answers after its wait.
    for (int s = 0; s < SP; s++) begin
      rdy[s] = 1'($urandom);
      rd[s*DW +: DW] = DW'($urandom);
    end
    if (t_active && t_mapped && cyc >= t_g + 2 && cyc < t_r) begin
      rdy[t_slave] = ((cyc - (t_g + 2)) >= int'(t_wt));
      rd[t_slave*DW +: DW] = t_sdata;
    end
    bus.M_PREADY = rdy;
    bus.M_PRDATA = rd;
    // Arbitration when the bus is free this cycle.
    if (cyc > last_r) begin
      found = 1'b0; gm = 0;
      for (int k = 1; k <= MP; k++) begin
        cand = (last_g + k) % MP;
        if (!found && mphase[cand] == 2) begin found = 1'b1; gm = cand; end
      end
      if (found) begin
        a = cur[gm];
        t_active = 1'b1; t_m = gm; t_g = cyc; t_wt = a.wt; t_sdata = a.rdata;
        t_slave = int'(a.addr >> SS);
        t_mapped = (t_slave < SP);
        if (!t_mapped) begin
          t_r = cyc + 1; t_err = 1'b1; t_rdata = '0;
        end else begin
          t_err = (TO != 0) && (a.wt >= TO);
          len = t_err ? TO : int'(a.wt) + 1;
          t_rdata = t_err ? '0 : a.rdata;
          t_r = cyc + 2 + len;
        end
        last_g = gm; last_r = t_r;
        lat_addr = a.addr; lat_wr = a.wr; lat_wd = a.wdata;
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while (n < budget && !idle()) begin
      step();
      n++;
    end
    if (!idle()) begin
      errors++;
      $display("FAIL run_idle: stimulus did not drain within %0d cycles", budget);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "bench stalled");
    end
  endtask

  initial begin
    int n;
    int unsigned r, wt;
    reset = 1'b1;
    bus.S_PADDR = '0; bus.S_PWDATA = '0; bus.S_PSELx = '0;
    bus.S_PENABLE = '0; bus.S_PWRITE = '0;
    bus.M_PREADY = '0; bus.M_PRDATA = '0;
    for (int i = 0; i < MP; i++) begin mphase[i] = 0; mloaded[i] = 1'b0; mgap[i] = 0; end
    @(negedge clk);
    @(negedge clk);
    check_outputs('0, 1'b0, '0, '0, '0);
    reset = 1'b0;

    // Zero-wait write to slave 1.
    push(0, 16'h0105, 1'b1, 16'hBEEF, 16'h5A5A, 0, 0);
    run_idle(100);
    // Read with 5 wait states: ready lands on the last cycle before timeout.
    push(1, 16'h0203, 1'b0, 16'h0000, 16'h1234, 5, 0);
    run_idle(100);
    // Both masters requesting continuously: alternating grants.
    for (int k = 0; k < 3; k++) begin
      push(0, AW'(16'h0010 + k), 1'b1, DW'($urandom), DW'($urandom), k, 0);
      push(1, AW'(16'h0120 + k), 1'b0, DW'($urandom), DW'($urandom), 1, 0);
    end
    run_idle(200);
    // Unmapped slave index.
    push(0, 16'h0700, 1'b0, 16'h0000, 16'hFFFF, 0, 0);
    run_idle(50);
    // Never-ready slave times out, then M1 gets the bus; wait == TIMEOUT also errors.
    push(0, 16'h0302, 1'b0, 16'h0000, 16'hAAAA, 99, 0);
    push(1, 16'h0104, 1'b1, 16'h7777, 16'h3333, 2, 0);
    push(0, 16'h0301, 1'b0, 16'h0000, 16'hBBBB, TO, 1);
    run_idle(200);

    // Reset in the middle of an ACCESS phase.
    push(0, 16'h0300, 1'b0, 16'h0000, 16'hCCCC, 99, 0);
    n = 0;
    while (!(t_active && cyc == t_g + 3) && n < 50) begin step(); n++; end
    #1 reset = 1'b1;
    #1;
    check("rst_m_psel",    64'(bus.M_PSELx),   64'd0);
    check("rst_m_penable", 64'(bus.M_PENABLE), 64'd0);
    check("rst_s_pready",  64'(bus.S_PREADY),  64'd0);
    check("rst_m_paddr",   64'(bus.M_PADDR),   64'd0);
    for (int i = 0; i < MP; i++) begin
      mq[i].delete(); mphase[i] = 0; mloaded[i] = 1'b0; mgap[i] = 0;
    end
    drive_masters();
    t_active = 1'b0; last_g = MP - 1; last_r = cyc;
    lat_addr = '0; lat_wr = 1'b0; lat_wd = '0;
    #1 reset = 1'b0;
    push(1, 16'h0201, 1'b1, 16'h1111, 16'h2222, 0, 0);
    push(0, 16'h0102, 1'b1, 16'h3333, 16'h4444, 0, 0);
    run_idle(100);

    // Randomized traffic, including wait values around the timeout.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      wt = (r < 6) ? r : (r == 6) ? TO - 1 : (r == 7) ? TO : (r == 8) ? 0 : 40;
      push(k % MP, {8'($urandom_range(0, 5)), 8'($urandom)}, 1'($urandom),
           DW'($urandom), DW'($urandom), wt, $urandom_range(0, 3));
    end
    run_idle(5000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
